pixel_sram_reader: RTL



---
 rtl/pixel_sram_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pixel_sram_reader.sv
// ---------------------------------------------------------------------------
// pixel_sram_reader
//
// CPU readback engine for the external-SRAM pixel framebuffer. A single-pixel
// read command is accepted, pending framebuffer writes are allowed to drain,
// a read slot is requested from the SRAM arbiter and the returned R3G3B2 byte
// is handed back together with a one-cycle done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for cpu_start
// FLUSH  | address latched, waiting for the write FIFO to drain
// REQ    | arb_req held high, waiting for arb_grant (bounded by TIMEOUT)
// WAIT   | grant seen, counting down the SRAM read latency
// DONE   | cpu_done (and cpu_err if flagged) high for this one cycle
//
// Ports:
//   clk100       arbiter clock, all logic on rising edge
//   reset        synchronous active-high reset
//   cpu_addr     pixel index, sampled with cpu_start
//   cpu_start    read command, accepted in IDLE or DONE
//   cpu_busy     command in progress (FLUSH, REQ, WAIT)
//   cpu_q        read data, held until the next completion
//   cpu_done     one-cycle completion pulse
//   cpu_err      one-cycle pulse with cpu_done on out-of-range or timeout
//   wfifo_empty  SRAM write FIFO has no pending CPU writes
//   arb_req      read slot request
//   arb_addr     SRAM byte address for the request
//   arb_grant    one-cycle pulse: arbiter has issued the read of arb_addr
//   arb_rdata    SRAM data, valid READ_LATENCY cycles after grant
// ---------------------------------------------------------------------------
module pixel_sram_reader #(
    parameter logic [18:0] FB_BASE      = 19'h00000,
    parameter int          FB_PIXELS    = 76800,
    parameter int          READ_LATENCY = 2,
    parameter int          TIMEOUT      = 4095
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic [16:0] cpu_addr,
    input  logic        cpu_start,
    output logic        cpu_busy,
    output logic [7:0]  cpu_q,
    output logic        cpu_done,
    output logic        cpu_err,
    input  logic        wfifo_empty,
    output logic        arb_req,
    output logic [18:0] arb_addr,
    input  logic        arb_grant,
    input  logic [7:0]  arb_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // One bit wider than cpu_addr so a full 2^17 pixel count still compares.
    localparam logic [17:0] PIX_LIMIT = 18'(FB_PIXELS);
    // Down-counters terminate at zero, so they are loaded with count-1.
    localparam logic [2:0]  LAT_LOAD  = 3'(READ_LATENCY - 1);
    localparam logic [11:0] TMO_LOAD  = 12'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  q_n;
    logic [18:0] addr_n;
    logic        req_n;
    logic        err_flag, err_n;
    logic [2:0]  lat_cnt, lat_n;
    logic [11:0] tmo_cnt, tmo_n;
    logic        addr_oob;

    assign addr_oob = ({1'b0, cpu_addr} >= PIX_LIMIT);

    always_ff @(posedge clk100) begin
        if (reset) begin
            state    <= S_IDLE;
            cpu_q    <= 8'h00;
            arb_req  <= 1'b0;
            arb_addr <= 19'h00000;
            err_flag <= 1'b0;
            lat_cnt  <= 3'd0;
            tmo_cnt  <= 12'd0;
        end else begin
            state    <= state_n;
            cpu_q    <= q_n;
            arb_req  <= req_n;
            arb_addr <= addr_n;
            err_flag <= err_n;
            lat_cnt  <= lat_n;
            tmo_cnt  <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = cpu_q;
        addr_n  = arb_addr;
        req_n   = arb_req;
        err_n   = err_flag;
        lat_n   = lat_cnt;
        tmo_n   = tmo_cnt;

        case (state)
            // DONE behaves like IDLE for command acceptance so a new read
            // can be issued in the completion cycle.
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                err_n   = 1'b0;
                if (cpu_start) begin
                    if (addr_oob) begin
                        q_n     = 8'h00;
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        addr_n  = FB_BASE + {2'b00, cpu_addr};
                        state_n = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (wfifo_empty) begin
                    req_n   = 1'b1;
                    tmo_n   = TMO_LOAD;
                    state_n = S_REQ;
                end
            end

            // Grant is checked first so it wins over an expiring timeout.
            S_REQ: begin
                if (arb_grant) begin
                    req_n   = 1'b0;
                    lat_n   = LAT_LOAD;
                    state_n = S_WAIT;
                end else if (tmo_cnt == 12'd0) begin
                    req_n   = 1'b0;
                    q_n     = 8'h00;
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    tmo_n = tmo_cnt - 12'd1;
                end
            end

            S_WAIT: begin
                if (lat_cnt == 3'd0) begin
                    q_n     = arb_rdata;
                    state_n = S_DONE;
                end else begin
                    lat_n = lat_cnt - 3'd1;
                end
            end

            default: begin
                req_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign cpu_busy = (state == S_FLUSH) || (state == S_REQ) || (state == S_WAIT);
    assign cpu_done = (state == S_DONE);
    assign cpu_err  = (state == S_DONE) && err_flag;

endmodule
